// File: rtl/bridge_sensor_frontend_if.sv
// Sensor-side bundle for the bridge front end: raw switch/sensor inputs and
// the conditioned levels, pulses and car-count status returned to the controller.
interface bridge_sensor_frontend_if #(
    parameter int COUNT_WIDTH = 4
);
    logic                   CAIN_raw;
    logic                   CAO_raw;
    logic                   MD_raw;
    logic                   PB_raw;
    logic                   BS_raw;
    logic                   H_raw;
    logic                   L_raw;

    logic                   MD;
    logic                   BS;
    logic                   H;
    logic                   L;
    logic                   CAIN;
    logic                   CAO;
    logic                   PB;
    logic [COUNT_WIDTH-1:0] CarCount;
    logic                   Occupied;
    logic                   CntErr;
    logic                   SensorFault;

    modport master (
        output CAIN_raw, CAO_raw, MD_raw, PB_raw, BS_raw, H_raw, L_raw,
        input  MD, BS, H, L, CAIN, CAO, PB, CarCount, Occupied, CntErr, SensorFault
    );

    modport slave (
        input  CAIN_raw, CAO_raw, MD_raw, PB_raw, BS_raw, H_raw, L_raw,
        output MD, BS, H, L, CAIN, CAO, PB, CarCount, Occupied, CntErr, SensorFault
    );
endinterface

// File: rtl/bridge_sensor_frontend.sv
// Bridge sensor conditioning: 2-flop sync, optional debounce (SENSOR_DEBOUNCE_EN),
// registered levels, rising-edge pulses and a saturating car occupancy counter.
module bridge_sensor_frontend #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_WIDTH     = 4
) (
    input logic                     Clk,
    input logic                     Reset,
    bridge_sensor_frontend_if.slave bus
);
    localparam int NCH     = 7;
    localparam int CH_CAIN = 0;
    localparam int CH_CAO  = 1;
    localparam int CH_MD   = 2;
    localparam int CH_PB   = 3;
    localparam int CH_BS   = 4;
    localparam int CH_H    = 5;
    localparam int CH_L    = 6;

    // Only the bridge-low path idles high: the bridge rests flat.
    localparam logic [NCH-1:0]         RST_LVL = 7'b100_0000;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    generate
        if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_cfg
            $error("DEBOUNCE_CYCLES must lie in 1..15");
        end
    endgenerate

    logic [NCH-1:0] raw;
    logic [NCH-1:0] meta_q;
    logic [NCH-1:0] sync_q;
    logic [NCH-1:0] filt;
    logic [NCH-1:0] lvl_q;
    logic [2:0]     pulse_q;

    assign raw = {bus.L_raw, bus.H_raw, bus.BS_raw, bus.PB_raw,
                  bus.MD_raw, bus.CAO_raw, bus.CAIN_raw};

    // Stage: two-flop synchronizer
    always_ff @(posedge Clk) begin
        if (Reset) begin
            meta_q <= RST_LVL;
            sync_q <= RST_LVL;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    // Stage: debounce filter (or straight through)
`ifdef SENSOR_DEBOUNCE_EN
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic [3:0]     db_cnt_q [NCH];
    logic [NCH-1:0] db_lvl_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            db_lvl_q <= RST_LVL;
            for (int i = 0; i < NCH; i++) db_cnt_q[i] <= 4'd0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync_q[i] == db_lvl_q[i]) begin
                    db_cnt_q[i] <= 4'd0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_lvl_q[i] <= sync_q[i];
                    db_cnt_q[i] <= 4'd0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 4'd1;
                end
            end
        end
    end

    assign filt = db_lvl_q;
`else
    assign filt = sync_q;
`endif

    // Stage: level registers and rising-edge pulses
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lvl_q   <= RST_LVL;
            pulse_q <= 3'b000;
        end else begin
            lvl_q   <= filt;
            pulse_q <= {filt[CH_PB]   & ~lvl_q[CH_PB],
                        filt[CH_CAO]  & ~lvl_q[CH_CAO],
                        filt[CH_CAIN] & ~lvl_q[CH_CAIN]};
        end
    end

    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   err_q, err_d;
    logic                   occ_q;
    logic                   fault_q;

    // Simultaneous entry and exit cancel; limits hold and latch the error.
    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        case (pulse_q[1:0])
            2'b01: begin
                if (count_q == CNT_MAX) err_d   = 1'b1;
                else                    count_d = count_q + CNT_ONE;
            end
            2'b10: begin
                if (count_q == '0) err_d   = 1'b1;
                else               count_d = count_q - CNT_ONE;
            end
            default: ;
        endcase
    end

    // Stage: occupancy counter and status flags
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
            err_q   <= 1'b0;
            occ_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
            occ_q   <= (count_q != '0);
            fault_q <= lvl_q[CH_H] & lvl_q[CH_L];
        end
    end

    assign bus.MD          = lvl_q[CH_MD];
    assign bus.BS          = lvl_q[CH_BS];
    assign bus.H           = lvl_q[CH_H];
    assign bus.L           = lvl_q[CH_L];
    assign bus.CAIN        = pulse_q[0];
    assign bus.CAO         = pulse_q[1];
    assign bus.PB          = pulse_q[2];
    assign bus.CarCount    = count_q;
    assign bus.Occupied    = occ_q;
    assign bus.CntErr      = err_q;
    assign bus.SensorFault = fault_q;
endmodule

// File: tb/tb_bridge_sensor_frontend.sv
// Scoreboard bench for bridge_sensor_frontend: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_bridge_sensor_frontend;
`ifdef SENSOR_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif
    localparam int LAT = 3 + DB;

    localparam int S_MD    = 0;
    localparam int S_BS    = 1;
    localparam int S_H     = 2;
    localparam int S_L     = 3;
    localparam int S_CAIN  = 4;
    localparam int S_CAO   = 5;
    localparam int S_PB    = 6;
    localparam int S_CNT   = 7;
    localparam int S_OCC   = 8;
    localparam int S_ERR   = 9;
    localparam int S_FAULT = 10;

    logic Clk = 1'b0;
    logic Reset;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    bridge_sensor_frontend_if #(.COUNT_WIDTH(4)) bus ();

    bridge_sensor_frontend #(
        .DEBOUNCE_CYCLES(4),
        .COUNT_WIDTH(4)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct packed {
        int cyc;
        int sig;
        int val;
    } exp_t;

    exp_t sbq[$];

    function automatic string sig_name(input int s);
        case (s)
            S_MD:    return "MD";
            S_BS:    return "BS";
            S_H:     return "H";
            S_L:     return "L";
            S_CAIN:  return "CAIN";
            S_CAO:   return "CAO";
            S_PB:    return "PB";
            S_CNT:   return "CarCount";
            S_OCC:   return "Occupied";
            S_ERR:   return "CntErr";
            default: return "SensorFault";
        endcase
    endfunction

    function automatic int get_sig(input int s);
        case (s)
            S_MD:    return int'(bus.MD);
            S_BS:    return int'(bus.BS);
            S_H:     return int'(bus.H);
            S_L:     return int'(bus.L);
            S_CAIN:  return int'(bus.CAIN);
            S_CAO:   return int'(bus.CAO);
            S_PB:    return int'(bus.PB);
            S_CNT:   return int'(bus.CarCount);
            S_OCC:   return int'(bus.Occupied);
            S_ERR:   return int'(bus.CntErr);
            default: return int'(bus.SensorFault);
        endcase
    endfunction

    task automatic expect_at(input int c, input int s, input int v);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Monitor: compare every expectation stamped for the current edge.
    always @(negedge Clk) begin
        int act;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc <= cyc) begin
                act = get_sig(sbq[i].sig);
                checks++;
                if (sbq[i].cyc < cyc || act != sbq[i].val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d (due %0d) actual=%0d expected=%0d",
                             sig_name(sbq[i].sig), cyc, sbq[i].cyc, act, sbq[i].val);
                end
                sbq.delete(i);
            end
        end
    end

    task automatic do_reset(input int n);
        int e0;
        e0 = cyc;
        Reset = 1'b1;
        for (int s = S_MD; s <= S_FAULT; s++) expect_at(e0 + 1, s, (s == S_L) ? 1 : 0);
        tick(n);
        Reset = 1'b0;
        expect_at(e0 + n + 1, S_CAIN, 0);
        expect_at(e0 + n + 1, S_CAO, 0);
        expect_at(e0 + n + 1, S_PB, 0);
    endtask

    task automatic car_event(input bit is_in, input int cnt_after, input int err_after);
        int e0;
        int s;
        e0 = cyc;
        s  = is_in ? S_CAIN : S_CAO;
        if (is_in) bus.CAIN_raw = 1'b1;
        else       bus.CAO_raw  = 1'b1;
        expect_at(e0 + LAT - 1, s, 0);
        expect_at(e0 + LAT, s, 1);
        expect_at(e0 + LAT + 1, s, 0);
        expect_at(e0 + LAT + 1, S_CNT, cnt_after);
        expect_at(e0 + LAT + 1, S_ERR, err_after);
        expect_at(e0 + LAT + 2, S_OCC, (cnt_after != 0) ? 1 : 0);
        tick(6);
        bus.CAIN_raw = 1'b0;
        bus.CAO_raw  = 1'b0;
        tick(8);
    endtask

    task automatic both_event(input int cnt);
        int e0;
        e0 = cyc;
        bus.CAIN_raw = 1'b1;
        bus.CAO_raw  = 1'b1;
        expect_at(e0 + LAT, S_CAIN, 1);
        expect_at(e0 + LAT, S_CAO, 1);
        expect_at(e0 + LAT + 1, S_CNT, cnt);
        expect_at(e0 + LAT + 2, S_CNT, cnt);
        expect_at(e0 + LAT + 1, S_ERR, 0);
        tick(6);
        bus.CAIN_raw = 1'b0;
        bus.CAO_raw  = 1'b0;
        tick(8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        Reset        = 1'b1;
        bus.CAIN_raw = 1'b0;
        bus.CAO_raw  = 1'b0;
        bus.MD_raw   = 1'b0;
        bus.PB_raw   = 1'b0;
        bus.BS_raw   = 1'b0;
        bus.H_raw    = 1'b0;
        bus.L_raw    = 1'b1;

        // Power-on reset, then idle levels once the pipeline has filled.
        do_reset(2);
        e = cyc;
        expect_at(e + LAT + 1, S_L, 1);
        expect_at(e + LAT + 1, S_MD, 0);
        expect_at(e + LAT + 1, S_BS, 0);
        expect_at(e + LAT + 1, S_H, 0);
        expect_at(e + LAT + 1, S_CNT, 0);
        expect_at(e + LAT + 1, S_OCC, 0);
        expect_at(e + LAT + 1, S_ERR, 0);
        expect_at(e + LAT + 1, S_FAULT, 0);
        tick(LAT + 2);

        // One car in, one car out.
        car_event(1'b1, 1, 0);
        car_event(1'b0, 0, 0);

        // Boat sensor chattering every cycle.
        e = cyc;
        for (int k = 0; k < 20; k++) begin
            bus.BS_raw = (k % 2 == 0);
            expect_at(e + k + LAT, S_BS, (DB != 0) ? 0 : ((k % 2 == 0) ? 1 : 0));
            tick(1);
        end
        bus.BS_raw = 1'b0;
        expect_at(e + 20 + LAT, S_BS, 0);
        tick(LAT + 8);

        // Fill to saturation, overflow, then one exit.
        for (int k = 1; k <= 16; k++) car_event(1'b1, (k > 15) ? 15 : k, (k > 15) ? 1 : 0);
        car_event(1'b0, 14, 1);

        // Fresh count: simultaneous in/out at 3, then drain and underflow.
        do_reset(1);
        for (int k = 1; k <= 3; k++) car_event(1'b1, k, 0);
        both_event(3);
        for (int k = 2; k >= 0; k--) car_event(1'b0, k, 0);
        car_event(1'b0, 0, 1);

        // High and low both asserted -> sensor fault.
        e = cyc;
        bus.H_raw = 1'b1;
        expect_at(e + LAT - 1, S_H, 0);
        expect_at(e + LAT, S_H, 1);
        expect_at(e + LAT, S_FAULT, 0);
        expect_at(e + LAT + 1, S_FAULT, 1);
        tick(LAT + 3);

        // Reset lands while MD is still travelling through the filter.
        bus.MD_raw = 1'b1;
        tick(4);
        e = cyc;
        do_reset(1);
        expect_at(e + LAT, S_MD, 0);
        expect_at(e + 1 + LAT, S_MD, 1);
        expect_at(e + 1 + LAT, S_H, 1);
        expect_at(e + 2 + LAT, S_FAULT, 1);
        tick(LAT + 4);

        // Held push button pulses exactly once.
        e = cyc;
        bus.PB_raw = 1'b1;
        expect_at(e + LAT, S_PB, 1);
        for (int k = 1; k <= 5; k++) expect_at(e + LAT + k, S_PB, 0);
        tick(10);
        bus.PB_raw = 1'b0;
        tick(LAT + 4);

        tick(3);
        if (sbq.size() != 0) begin
            errors += sbq.size();
            $display("FAIL pending cyc=%0d actual=%0d expected=0", cyc, sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
